// File: rtl/nxs_work_loader.sv
// nxs_work_loader: streams work packets into a shadow register and commits them to the hashers.
// Define WORK_CSUM_EN to append and verify a trailing XOR checksum byte.
module nxs_work_loader #(
   parameter int HOLD_CYCLES = 2,
   parameter int TIMEOUT     = 65535
) (
   input  logic          clk,
   input  logic          nRst,
   input  logic [7:0]    InData,
   input  logic          InValid,
   output logic          InReady,
   output logic [1727:0] WorkPkt,
   output logic [63:0]   InNonce,
   output logic          nHashRst,
   output logic          WorkValid,
   output logic          CsumErr,
   output logic          PktTimeout
);

`ifdef WORK_CSUM_EN
   localparam logic [7:0] LAST_IDX = 8'd224;
`else
   localparam logic [7:0] LAST_IDX = 8'd223;
`endif
   localparam logic [7:0]  HOLD_W = 8'(HOLD_CYCLES);
   localparam logic [16:0] TO_W   = 17'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RECV,
      S_COMMIT
`ifdef WORK_CSUM_EN
      , S_CHECK
`endif
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [15:0]     idle_q, idle_d;
   logic [7:0]      hold_q, hold_d;
   logic [1791:0]   shadow_q, shadow_d;
   logic [1727:0]   work_q, work_d;
   logic [63:0]     nonce_q, nonce_d;
   logic            nhash_q, nhash_d;
   logic            valid_q, valid_d;
   logic            ready_q, ready_d;
   logic            tmo_q, tmo_d;
`ifdef WORK_CSUM_EN
   logic [7:0]      csum_q, csum_d;
   logic            cerr_q, cerr_d;
`endif

   logic            accept;
   logic [16:0]     idle_inc;
   logic [10:0]     byte_idx;

   assign accept   = InValid & ready_q;
   assign idle_inc = {1'b0, idle_q} + 17'd1;
   assign byte_idx = {cnt_q, 3'b000};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idle_d   = idle_q;
      hold_d   = hold_q;
      shadow_d = shadow_q;
      work_d   = work_q;
      nonce_d  = nonce_q;
      nhash_d  = nhash_q;
      valid_d  = valid_q;
      tmo_d    = 1'b0;
`ifdef WORK_CSUM_EN
      csum_d   = csum_q;
      cerr_d   = 1'b0;
      if (accept)
         csum_d = (state_q == S_IDLE) ? InData : (csum_q ^ InData);
`endif
      // the checksum byte lands past the shadow and is only folded into csum
      if (accept && cnt_q < 8'd224)
         shadow_d[byte_idx +: 8] = InData;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               cnt_d   = 8'd1;
               idle_d  = '0;
               state_d = S_RECV;
            end
         end
         S_RECV: begin
            if (accept) begin
               idle_d = '0;
               if (cnt_q == LAST_IDX) begin
                  cnt_d = '0;
`ifdef WORK_CSUM_EN
                  state_d = S_CHECK;
`else
                  state_d = S_COMMIT;
`endif
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end else if (idle_inc == TO_W) begin
               tmo_d   = 1'b1;
               cnt_d   = '0;
               idle_d  = '0;
               state_d = S_IDLE;
            end else begin
               idle_d = idle_inc[15:0];
            end
         end
`ifdef WORK_CSUM_EN
         S_CHECK: begin
            if (csum_q == 8'd0) begin
               state_d = S_COMMIT;
            end else begin
               cerr_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
`endif
         S_COMMIT: begin
            if (hold_q == 8'd0) begin
               work_d  = shadow_q[1727:0];
               nonce_d = shadow_q[1791:1728];
               nhash_d = 1'b0;
               valid_d = 1'b1;
               hold_d  = 8'd1;
            end else if (hold_q == HOLD_W) begin
               nhash_d = 1'b1;
               hold_d  = '0;
               state_d = S_IDLE;
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      ready_d = (state_d == S_IDLE) || (state_d == S_RECV);
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idle_q   <= '0;
         hold_q   <= '0;
         shadow_q <= '0;
         work_q   <= '0;
         nonce_q  <= '0;
         nhash_q  <= 1'b0;
         valid_q  <= 1'b0;
         ready_q  <= 1'b0;
         tmo_q    <= 1'b0;
`ifdef WORK_CSUM_EN
         csum_q   <= '0;
         cerr_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idle_q   <= idle_d;
         hold_q   <= hold_d;
         shadow_q <= shadow_d;
         work_q   <= work_d;
         nonce_q  <= nonce_d;
         nhash_q  <= nhash_d;
         valid_q  <= valid_d;
         ready_q  <= ready_d;
         tmo_q    <= tmo_d;
`ifdef WORK_CSUM_EN
         csum_q   <= csum_d;
         cerr_q   <= cerr_d;
`endif
      end
   end

   assign InReady    = ready_q;
   assign WorkPkt    = work_q;
   assign InNonce    = nonce_q;
   assign nHashRst   = nhash_q;
   assign WorkValid  = valid_q;
   assign PktTimeout = tmo_q;
`ifdef WORK_CSUM_EN
   assign CsumErr    = cerr_q;
`else
   assign CsumErr    = 1'b0;
`endif

endmodule
